hex_display_sequencer: RTL

Sequences one shared hex-to-seven-segment decode path across NUM_DIGITS display digits, for example HEX5..HEX0 showing frequency or sample values from the audio datapath. A multi-nibble value is accepted through a valid/ready handshake and latched. The block then walks the digits one per clock, from most to least significant, and writes each decoded pattern into a per-digit output register. Optional leading-zero blanking is supported, and a done pulse marks the end of each update.

---
 rtl/hex_display_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/hex_display_sequencer.sv
// Time-multiplexes one hex-to-seven-segment decoder across NUM_DIGITS digit
// registers, scanning the latched value from the most to the least significant digit.
module hex_display_sequencer #(
  parameter int NUM_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_zeros,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [7*NUM_DIGITS-1:0] segments,
  output logic                    update_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] value_q;
  logic                    blank_q;
  logic                    seen_nonzero;

  logic [3:0] nibble;
  logic       blank_digit;
  logic [6:0] pattern;

  // Active-low patterns; bit 0 = segment a, bit 6 = segment g.
  function automatic logic [6:0] hex_decode(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Shared decode path: pick the nibble at the current scan position.
  always_comb begin
    nibble = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) nibble = value_q[4*i +: 4];
    end
  end

  // Digit 0 is never blanked so a zero value still shows "0".
  assign blank_digit = blank_q && (nibble == 4'd0) && !seen_nonzero && (idx != '0);
  assign pattern     = blank_digit ? SEG_BLANK : hex_decode(nibble);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      value_q      <= '0;
      blank_q      <= 1'b0;
      seen_nonzero <= 1'b0;
      segments     <= '1;
      load_ready   <= 1'b1;
      update_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid && load_ready) begin
            value_q      <= value;
            blank_q      <= blank_zeros;
            idx          <= LAST_IDX;
            seen_nonzero <= 1'b0;
            load_ready   <= 1'b0;
            state        <= SCAN;
          end
        end
        SCAN: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) segments[7*i +: 7] <= pattern;
          end
          seen_nonzero <= seen_nonzero | (nibble != 4'd0);
          if (idx == '0) begin
            update_done <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          update_done <= 1'b0;
          load_ready  <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          update_done <= 1'b0;
          load_ready  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
